// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
//   Round-robin arbiter that shares one single-port synchronous instruction
//   RAM among NUM_CORES fetch units. One request is granted per cycle. The
//   RAM address is driven in the grant cycle, and the read data comes back
//   to the granted core one cycle later, tagged by a one-hot rvalid strobe.
//
// Optional feature (macro IMEM_ADDR_CHECK_EN):
//   A winning request whose address is >= DATA_MEM_START is still granted,
//   but the RAM is not enabled. The next cycle returns rvalid together with
//   addr_err for that core, and rdata reads 0.
//   Without the macro, every grant goes to the RAM and addr_err is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   en         global enable; 0 blocks new grants
//   req        per-core fetch request (bit i = core i)
//   req_addr   flattened fetch addresses, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   grant      one-hot combinational accept
//   rvalid     one-hot registered response strobe
//   rdata      returned instruction, meaningful while rvalid != 0
//   mem_en     RAM read enable
//   mem_addr   RAM read address
//   mem_rdata  RAM read data, valid the cycle after mem_en
//   addr_err   one-hot registered address-error strobe
module imem_fetch_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_WIDTH     = 10,
  parameter int INST_WIDTH     = 32,
  parameter int DATA_MEM_START = 512
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             en,
  input  logic [NUM_CORES-1:0]             req,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  req_addr,
  output logic [NUM_CORES-1:0]             grant,
  output logic [NUM_CORES-1:0]             rvalid,
  output logic [INST_WIDTH-1:0]            rdata,
  output logic                             mem_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [INST_WIDTH-1:0]            mem_rdata,
  output logic [NUM_CORES-1:0]             addr_err
);

  localparam int          PTR_W = $clog2(NUM_CORES);
  localparam int unsigned NC    = NUM_CORES;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      next_ptr;
  logic                  found;
  logic                  grant_any;
  logic                  addr_bad;
  logic [ADDR_WIDTH-1:0] win_addr;

  // Scan starts at rr_ptr and wraps modulo NUM_CORES. NUM_CORES may be a
  // non-power-of-two, so the wrap is an explicit subtraction and not a
  // truncation.
  always_comb begin : arbitrate
    int unsigned idx;
    logic [PTR_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NC) idx = idx - NC;
      cand = idx[PTR_W-1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_any = en & found;
    win_addr  = req_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    grant     = grant_any ? (NUM_CORES'(1) << winner) : '0;
    mem_addr  = grant_any ? win_addr : '0;
    mem_en    = grant_any & ~addr_bad;
    next_ptr  = (winner == PTR_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      rvalid <= '0;
    end else begin
      if (grant_any) rr_ptr <= next_ptr;
      rvalid <= grant;
    end
  end

`ifdef IMEM_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DATA_START = (ADDR_WIDTH+1)'(DATA_MEM_START);

  logic [NUM_CORES-1:0] err_q;

  // The extra bit keeps the compare correct when DATA_MEM_START equals
  // 2**ADDR_WIDTH, which means no address is rejected.
  assign addr_bad = ({1'b0, win_addr} >= DATA_START);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= addr_bad ? grant : '0;
  end

  // The RAM was not read for a rejected fetch, so its output is stale.
  assign addr_err = err_q;
  assign rdata    = (|err_q) ? '0 : mem_rdata;
`else
  assign addr_bad = 1'b0;
  assign addr_err = '0;
  assign rdata    = mem_rdata;
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
module tb_imem_fetch_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int IW = 32;
  localparam int DS = 512;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  grant;
  logic [N-1:0]  rvalid;
  logic [IW-1:0] rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata = '0;
  logic [N-1:0]  addr_err;

  imem_fetch_arbiter #(
    .NUM_CORES(N), .ADDR_WIDTH(AW), .INST_WIDTH(IW), .DATA_MEM_START(DS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req), .req_addr(req_addr),
    .grant(grant), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM whose contents are a known function of the address.
  always @(posedge clk) if (mem_en) mem_rdata <= 32'hC0DE_0000 | 32'(mem_addr);

  typedef struct packed {
    logic [N-1:0]  vld;
    logic [N-1:0]  err;
    logic [IW-1:0] data;
  } resp_t;

  resp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  function automatic logic [AW-1:0] addr_of(input int c);
    return req_addr[c*AW +: AW];
  endfunction

  function automatic int model_winner();
    if (!en) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic model_bad(input int c);
`ifdef IMEM_ADDR_CHECK_EN
    return addr_of(c) >= AW'(DS);
`else
    return 1'b0 && (c < 0);
`endif
  endfunction

  function automatic resp_t got_resp();
    resp_t g;
    g.vld  = rvalid;
    g.err  = addr_err;
    g.data = (rvalid != '0) ? rdata : '0;
    return g;
  endfunction

  function automatic resp_t next_exp();
    resp_t e;
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  // Records the response the current inputs should produce, then moves to
  // just after the next rising edge.
  task automatic advance();
    resp_t r;
    int w;
    w = model_winner();
    r = '0;
    if (w >= 0) begin
      r.vld = N'(1) << w;
      if (model_bad(w)) r.err = r.vld;
      else              r.data = 32'hC0DE_0000 | 32'(addr_of(w));
    end
    sb.push_back(r);
    @(posedge clk);
    if (w >= 0) m_ptr = (w + 1) % N;
    #1;
  endtask

  task automatic set_addr(input int c, input int a);
    req_addr[c*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    logic [2*N+1+AW-1:0] got;
    reset_n = 1'b0; en = 1'b0; req = '0;
    #12;
    got = {rvalid, addr_err, mem_en, mem_addr};
    checks++;
    if (got !== '0)
      $display("FAIL reset_state: rvalid=%b addr_err=%b mem_en=%b mem_addr=%0d, expected all 0",
               rvalid, addr_err, mem_en, mem_addr);
    if (got !== '0) errors++;
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL reset_grant: got %b expected 0000", grant);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    m_ptr = 0;
  endtask

  task automatic test_single();
    resp_t e, g;
    en = 1'b1; req = 4'b0001; set_addr(0, 5);
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e) begin errors++; $display("FAIL single_idle_resp: got %h expected %h", g, e); end
    checks++;
    if (grant !== 4'b0001 || mem_en !== 1'b1 || mem_addr !== AW'(5)) begin
      errors++;
      $display("FAIL single_grant: grant=%b mem_en=%b mem_addr=%0d, expected 0001 1 5", grant, mem_en, mem_addr);
    end
    advance();
    req = '0;
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e || rvalid !== 4'b0001 || rdata !== 32'hC0DE_0005) begin
      errors++;
      $display("FAIL single_resp: got %h expected %h", g, e);
    end
    advance();
  endtask

  task automatic test_rotation();
    resp_t e, g;
    logic [N-1:0] seq [8];
    int cnt [N];
    for (int i = 0; i < 8; i++) seq[i] = N'(1) << (i % N);
    for (int i = 0; i < N; i++) begin set_addr(i, 100 + 7*i); cnt[i] = 0; end
    // Park the pointer at 0 by serving core 3.
    en = 1'b1; req = 4'b1000;
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e) begin errors++; $display("FAIL rot_pre_resp: got %h expected %h", g, e); end
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL rot_park: grant=%b expected 1000", grant); end
    advance();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #2;
      e = next_exp(); g = got_resp(); checks++;
      if (g !== e) begin errors++; $display("FAIL rot_resp[%0d]: got %h expected %h", i, g, e); end
      checks++;
      if (grant !== seq[i]) begin
        errors++;
        $display("FAIL rot_grant[%0d]: grant=%b expected %b", i, grant, seq[i]);
      end
      for (int c = 0; c < N; c++) if (grant[c]) cnt[c]++;
      advance();
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if (cnt[c] !== 2) begin errors++; $display("FAIL rot_fair[%0d]: grants=%0d expected 2", c, cnt[c]); end
    end
  endtask

  task automatic test_wrap();
    resp_t e, g;
    logic [N-1:0] exp_g [3];
    exp_g[0] = 4'b0100; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      req = (i == 0) ? 4'b0100 : 4'b1001;
      #2;
      e = next_exp(); g = got_resp(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_resp[%0d]: got %h expected %h", i, g, e); end
      checks++;
      if (grant !== exp_g[i]) begin
        errors++;
        $display("FAIL wrap_grant[%0d]: grant=%b expected %b", i, grant, exp_g[i]);
      end
      advance();
    end
  endtask

  task automatic test_enable();
    resp_t e, g;
    en = 1'b0; req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #2;
      // The first pop is the response still in flight from the last grant.
      e = next_exp(); g = got_resp(); checks++;
      if (g !== e) begin errors++; $display("FAIL en_resp[%0d]: got %h expected %h", i, g, e); end
      checks++;
      if (grant !== '0 || mem_en !== 1'b0 || mem_addr !== '0) begin
        errors++;
        $display("FAIL en_off[%0d]: grant=%b mem_en=%b mem_addr=%0d expected 0 0 0", i, grant, mem_en, mem_addr);
      end
      advance();
    end
    en = 1'b1;
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e) begin errors++; $display("FAIL en_idle_resp: got %h expected %h", g, e); end
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL en_first: grant=%b expected 0010", grant); end
    advance();
  endtask

  task automatic test_back_to_back();
    resp_t e, g;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      set_addr(0, 40 + i);
      #2;
      e = next_exp(); g = got_resp(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_resp[%0d]: got %h expected %h", i, g, e); end
      checks++;
      if (grant !== 4'b0001 || mem_addr !== AW'(40 + i)) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: grant=%b mem_addr=%0d expected 0001 %0d", i, grant, mem_addr, 40 + i);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    resp_t e, g;
    req = 4'b0100; set_addr(2, 17);
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e) begin errors++; $display("FAIL rmid_pre_resp: got %h expected %h", g, e); end
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL rmid_grant: grant=%b expected 0100", grant); end
    advance();
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e || rdata !== 32'hC0DE_0011) begin
      errors++;
      $display("FAIL rmid_resp: got %h expected %h", g, e);
    end
    // Reset lands while the response is being presented; it must drop at once.
    en = 1'b0; req = '0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== '0) begin errors++; $display("FAIL rmid_drop: rvalid=%b expected 0000", rvalid); end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== '0) begin errors++; $display("FAIL rmid_hold: rvalid=%b expected 0000", rvalid); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    m_ptr = 0;
    en = 1'b1; req = 4'b1111;
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e) begin errors++; $display("FAIL rmid_post_resp: got %h expected %h", g, e); end
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_ptr: grant=%b expected 0001", grant); end
    advance();
  endtask

  task automatic test_addr_check();
    resp_t e, g;
    logic exp_en;
    logic [N-1:0] exp_err;
`ifdef IMEM_ADDR_CHECK_EN
    exp_en = 1'b0; exp_err = 4'b0010;
`else
    exp_en = 1'b1; exp_err = 4'b0000;
`endif
    req = 4'b0010; set_addr(1, 600);
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e) begin errors++; $display("FAIL achk_pre_resp: got %h expected %h", g, e); end
    checks++;
    if (grant !== 4'b0010 || mem_en !== exp_en) begin
      errors++;
      $display("FAIL achk_grant: grant=%b mem_en=%b expected 0010 %b", grant, mem_en, exp_en);
    end
    checks++;
    if (exp_en && mem_addr !== AW'(600)) begin
      errors++;
      $display("FAIL achk_addr: mem_addr=%0d expected 600", mem_addr);
    end
    advance();
    req = '0; en = 1'b0;
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e || addr_err !== exp_err || rvalid !== 4'b0010) begin
      errors++;
      $display("FAIL achk_resp: got %h expected %h", g, e);
    end
    advance();
    #2;
    e = next_exp(); g = got_resp(); checks++;
    if (g !== e) begin errors++; $display("FAIL drain_resp: got %h expected %h", g, e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    test_addr_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units, expected completion");
    $fatal(1);
  end
endmodule
